// File: rtl/pe_stream_driver_256.sv
// Router-side traffic generator/checker for a 256-bit PE wrapper link.
// Issues LFSR-derived request beats one at a time and checks each result for duplicated halves.
module pe_stream_driver_256 #(
    parameter int unsigned NUM_TXN   = 16,
    parameter int unsigned TIMEOUT   = 63,
    parameter logic [31:0] LFSR_SEED = 32'h0000_0001
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    output logic         m_tvalid,
    output logic [255:0] m_tdata_256,
    input  logic         m_tready,
    input  logic         s_tvalid,
    input  logic [255:0] s_tdata_256,
    output logic         s_tready,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic [15:0]  txn_count,
    output logic [7:0]   err_count,
    output logic [127:0] last_result
);

    localparam logic [31:0] SeedEff  = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;
    localparam logic [15:0] NumTxnW  = 16'(NUM_TXN);
    localparam logic [7:0]  TimeoutW = 8'(TIMEOUT);
    localparam logic [31:0] LfsrTaps = 32'h8020_0003;

    typedef enum logic [1:0] {StIdle, StSend, StWait, StDone} state_e;

    state_e         state_q, state_d;
    logic [31:0]    lfsr_q;
    logic [31:0]    lfsr_next;
    logic [7:0]     wait_cnt_q;
    logic [15:0]    txn_count_q;
    logic [7:0]     err_count_q;
    logic           error_q;
    logic [127:0]   last_result_q;
    logic [255:0]   payload;

    logic           start_ok;
    logic           req_fire;
    logic           rsp_fire;
    logic           timeout_hit;
    logic           completion;
    logic           mismatch;
    logic           run_last;
    logic [15:0]    txn_count_inc;

    always_comb begin
        start_ok      = start && (state_q == StIdle || state_q == StDone);
        req_fire      = (state_q == StSend) && m_tready;
        rsp_fire      = (state_q == StWait) && s_tvalid;
        // A response on the final wait cycle takes priority over the timeout.
        timeout_hit   = (state_q == StWait) && !s_tvalid && (wait_cnt_q == TimeoutW);
        completion    = rsp_fire || timeout_hit;
        mismatch      = rsp_fire && (s_tdata_256[255:128] != s_tdata_256[127:0]);
        txn_count_inc = txn_count_q + 16'd1;
        run_last      = (txn_count_inc == NumTxnW);
        lfsr_next     = lfsr_q[0] ? ((lfsr_q >> 1) ^ LfsrTaps) : (lfsr_q >> 1);
    end

    // Word k of the request is the LFSR rotated left by 4k bits.
    always_comb begin
        payload = '0;
        for (int k = 0; k < 8; k++) begin
            payload[32*k +: 32] = 32'(({lfsr_q, lfsr_q} << (4 * k)) >> 32);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_ok) state_d = StSend;
            StSend:  if (req_fire) state_d = StWait;
            StWait:  if (completion) state_d = run_last ? StDone : StSend;
            StDone:  if (start_ok) state_d = StSend;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        m_tvalid    = 1'b0;
        s_tready    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        m_tdata_256 = '0;
        unique case (state_q)
            StSend: begin
                m_tvalid    = 1'b1;
                busy        = 1'b1;
                m_tdata_256 = payload;
            end
            StWait: begin
                s_tready = 1'b1;
                busy     = 1'b1;
            end
            StDone:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q        <= SeedEff;
            wait_cnt_q    <= '0;
            txn_count_q   <= '0;
            err_count_q   <= '0;
            error_q       <= 1'b0;
            last_result_q <= '0;
        end else if (start_ok) begin
            lfsr_q      <= SeedEff;
            txn_count_q <= '0;
            err_count_q <= '0;
            error_q     <= 1'b0;
        end else begin
            if (req_fire) begin
                lfsr_q     <= lfsr_next;
                wait_cnt_q <= '0;
            end
            if (completion) begin
                txn_count_q <= txn_count_inc;
                if (rsp_fire) begin
                    last_result_q <= s_tdata_256[127:0];
                end
                if (mismatch || timeout_hit) begin
                    error_q <= 1'b1;
                    if (err_count_q != 8'hFF) begin
                        err_count_q <= err_count_q + 8'd1;
                    end
                end
            end else if (state_q == StWait) begin
                wait_cnt_q <= wait_cnt_q + 8'd1;
            end
        end
    end

    assign error       = error_q;
    assign txn_count   = txn_count_q;
    assign err_count   = err_count_q;
    assign last_result = last_result_q;

endmodule
